// File: rtl/machine_ctrl_if.sv
// machine_ctrl_if: control-bus bundle between the instruction-cycle controller and the CPU datapath
// master: controller side (samples ena/opcode/zero[/step], drives the datapath strobes)
// slave : datapath side (drives ena/opcode/zero[/step], samples the strobes)
// SINGLE_STEP_EN adds the step line.
interface machine_ctrl_if #(parameter int OPW = 3);
  logic ena;
  logic [OPW-1:0] opcode;
  logic zero;
`ifdef SINGLE_STEP_EN
  logic step;
`endif
  logic inc_pc;
  logic load_pc;
  logic load_ir;
  logic load_acc;
  logic rd;
  logic wr;
  logic datactl_ena;
  logic halt;
  modport master (
`ifdef SINGLE_STEP_EN
    input step,
`endif
    input ena, opcode, zero,
    output inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt
  );
  modport slave (
`ifdef SINGLE_STEP_EN
    output step,
`endif
    output ena, opcode, zero,
    input inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt
  );
endinterface

// File: rtl/machine_ctrl.sv
// machine_ctrl: 8-state fetch/execute controller for the 8-bit accumulator CPU
// clk    : system clock, rising edge
// rst    : synchronous reset, active-low, forces IDLE from any state
// io_ctl : machine_ctrl_if.master (ena, opcode, zero in; inc_pc, load_pc, load_ir,
//          load_acc, rd, wr, datactl_ena, halt out)
// SINGLE_STEP_EN adds io_ctl.step and a WAIT_STEP state between S7 and S0.
module machine_ctrl #(parameter int OPW = 3) (
  input logic clk,
  input logic rst,
  machine_ctrl_if.master io_ctl
);
  localparam logic [OPW-1:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, ANDD = 3'b011;
  localparam logic [OPW-1:0] XORR = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;
  typedef enum logic [3:0] {
    IDLE, S0, S1, S2, S3, S4, S5, S6, S7, HALTED
`ifdef SINGLE_STEP_EN
    , WAIT_STEP
`endif
  } state_t;
  state_t r_state;
  logic w_alu, w_jmp, w_sto, w_hlt, w_skz_t;
  assign w_alu = io_ctl.opcode inside {ADD, ANDD, XORR, LDA};
  assign w_jmp = io_ctl.opcode == JMP;
  assign w_sto = io_ctl.opcode == STO;
  assign w_hlt = io_ctl.opcode == HLT;
  assign w_skz_t = io_ctl.opcode == SKZ && io_ctl.zero;
  // HALTED ignores ena; every other state aborts to IDLE when ena drops
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else if (!io_ctl.ena && r_state != HALTED) r_state <= IDLE;
    else begin
      case (r_state)
        IDLE: r_state <= S0;
        S0: r_state <= S1;
        S1: r_state <= S2;
        S2: r_state <= S3;
        S3: r_state <= w_hlt ? HALTED : S4;
        S4: r_state <= S5;
        S5: r_state <= S6;
        S6: r_state <= S7;
`ifdef SINGLE_STEP_EN
        S7: r_state <= WAIT_STEP;
        WAIT_STEP: r_state <= io_ctl.step ? S0 : WAIT_STEP;
`else
        S7: r_state <= S0;
`endif
        HALTED: r_state <= HALTED;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign io_ctl.load_ir = r_state == S0 || r_state == S1;
  assign io_ctl.inc_pc = r_state == S0 || r_state == S1 || (w_skz_t && (r_state == S5 || r_state == S6));
  assign io_ctl.load_pc = w_jmp && (r_state == S4 || r_state == S5);
  assign io_ctl.load_acc = w_alu && r_state == S5;
  assign io_ctl.rd = r_state == S0 || r_state == S1 || (w_alu && (r_state == S4 || r_state == S5));
  assign io_ctl.wr = w_sto && r_state == S5;
  assign io_ctl.datactl_ena = w_sto && (r_state == S4 || r_state == S5 || r_state == S6);
  assign io_ctl.halt = r_state == HALTED || (r_state == S3 && w_hlt);
endmodule
